// File: rtl/pulse_pacer.sv
// Paces event strobes into single-cycle pulses spaced at least GAP clk_in cycles apart,
// keeping a saturating backlog count and a sticky flag for dropped events.
module pulse_pacer #(
    parameter int unsigned GAP       = 4,
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned EDGE_MODE = 0
) (
    input  logic             clk_in,
    input  logic             rst_in_n,
    input  logic             event_in,
    input  logic             clear,
    output logic             pulse_out,
    output logic [CNT_W-1:0] pending,
    output logic             overflow,
    output logic             busy
);

    localparam logic [CNT_W-1:0] MAX_PEND = '1;
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [7:0]       GAP_LOAD = 8'(GAP - 1);

    logic [7:0] gap_cnt;
    logic       ev_d;
    logic       ev;
    logic       emit;
    logic       full;
    logic       acc;
    logic       drop;

    always_comb begin
        ev   = (EDGE_MODE != 0) ? (event_in & ~ev_d) : event_in;
        emit = (gap_cnt == 8'd0) & ((pending != '0) | ev) & ~clear;
        full = (pending == MAX_PEND);
        // A full backlog still takes an event when a pulse leaves in the same cycle.
        acc  = ev & ~clear & ~(full & ~emit);
        drop = ev & ~clear & full & ~emit;
        busy = (pending != '0) | (gap_cnt != 8'd0) | pulse_out;
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            ev_d      <= 1'b0;
            pulse_out <= 1'b0;
            gap_cnt   <= 8'd0;
            pending   <= '0;
            overflow  <= 1'b0;
        end else begin
            ev_d      <= event_in;
            pulse_out <= emit;
            if (emit) begin
                gap_cnt <= GAP_LOAD;
            end else if (gap_cnt != 8'd0) begin
                gap_cnt <= gap_cnt - 8'd1;
            end
            // clear leaves gap_cnt alone so pulse spacing survives it.
            if (clear) begin
                pending  <= '0;
                overflow <= 1'b0;
            end else begin
                if (acc && !emit) begin
                    pending <= pending + ONE;
                end else if (!acc && emit) begin
                    pending <= pending - ONE;
                end
                if (drop) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pulse_pacer.sv
// Directed-vector bench for pulse_pacer: level-mode instance plus an edge-mode instance.
module tb_pulse_pacer;

    logic       clk_in = 1'b0;
    logic       rst_in_n;
    logic       event_in, clear;
    logic       pulse_out, overflow, busy;
    logic [3:0] pending;
    logic       e_event, e_clear;
    logic       e_pulse, e_overflow, e_busy;
    logic [3:0] e_pending;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk_in = ~clk_in;

    pulse_pacer #(.GAP(4), .CNT_W(4), .EDGE_MODE(0)) dut (
        .clk_in(clk_in), .rst_in_n(rst_in_n), .event_in(event_in), .clear(clear),
        .pulse_out(pulse_out), .pending(pending), .overflow(overflow), .busy(busy)
    );

    pulse_pacer #(.GAP(4), .CNT_W(4), .EDGE_MODE(1)) dut_e (
        .clk_in(clk_in), .rst_in_n(rst_in_n), .event_in(e_event), .clear(e_clear),
        .pulse_out(e_pulse), .pending(e_pending), .overflow(e_overflow), .busy(e_busy)
    );

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        if (obs != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample just after the edge.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check(tag, int'(busy), 0);
    endtask

    logic [12:0] lvl_pulse;
    int          lvl_pend [13];
    logic [12:0] lvl_busy;
    int          pulses, last, bad_gap;

    initial begin
        rst_in_n = 1'b0;
        event_in = 1'b0;
        clear    = 1'b0;
        e_event  = 1'b0;
        e_clear  = 1'b0;
        repeat (3) tick();
        check("rst_pulse", int'(pulse_out), 0);
        check("rst_pending", int'(pending), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_busy", int'(busy), 0);
        @(negedge clk_in);
        rst_in_n = 1'b1;
        repeat (2) tick();

        // Isolated event: one pulse next cycle, busy clears four edges later.
        event_in = 1'b1;
        tick();
        event_in = 1'b0;
        check("single_pulse", int'(pulse_out), 1);
        check("single_pend", int'(pending), 0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("single_nopulse", int'(pulse_out), 0);
            check("single_busy", int'(busy), (i < 3) ? 1 : 0);
        end
        check("single_pend_end", int'(pending), 0);
        repeat (2) tick();

        // Three back-to-back level events.
        lvl_pulse = 13'b0_0001_0001_0001;
        lvl_busy  = 13'b0_0111_1111_1111;
        lvl_pend  = '{0, 1, 2, 2, 1, 1, 1, 1, 0, 0, 0, 0, 0};
        for (int i = 0; i < 13; i++) begin
            event_in = (i < 3);
            tick();
            check($sformatf("lvl_pulse%0d", i), int'(pulse_out), int'(lvl_pulse[i]));
            check($sformatf("lvl_pend%0d", i), int'(pending), lvl_pend[i]);
            check($sformatf("lvl_busy%0d", i), int'(busy), int'(lvl_busy[i]));
        end
        event_in = 1'b0;

        // Held for 40 cycles: saturates, then exactly 15 pulses drain 4 apart.
        event_in = 1'b1;
        repeat (40) tick();
        event_in = 1'b0;
        check("sat_pend", int'(pending), 15);
        check("sat_ovf", int'(overflow), 1);
        pulses  = 0;
        last    = -1;
        bad_gap = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (pulse_out) begin
                if (last >= 0 && (i - last) != 4) bad_gap++;
                last = i;
                pulses++;
            end
        end
        check("sat_pulses", pulses, 15);
        check("sat_spacing_errs", bad_gap, 0);
        check("sat_busy", int'(busy), 0);
        check("sat_ovf_sticky", int'(overflow), 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("sat_ovf_clr", int'(overflow), 0);
        check("sat_pend_clr", int'(pending), 0);
        repeat (2) tick();

        // Clear with a concurrent event while five events are queued.
        event_in = 1'b1;
        repeat (7) tick();
        check("clr_pend5", int'(pending), 5);
        clear = 1'b1;
        tick();
        clear    = 1'b0;
        event_in = 1'b0;
        check("clr_pend", int'(pending), 0);
        check("clr_ovf", int'(overflow), 0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (pulse_out) pulses++;
        end
        check("clr_no_pulses", pulses, 0);

        // Clear just after an emit must not shorten the gap to the next pulse.
        event_in = 1'b1;
        tick();
        check("gap_p0", int'(pulse_out), 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("gap_p1", int'(pulse_out), 0);
        check("gap_pend1", int'(pending), 0);
        tick();
        check("gap_p2", int'(pulse_out), 0);
        tick();
        check("gap_p3", int'(pulse_out), 0);
        tick();
        event_in = 1'b0;
        check("gap_p4", int'(pulse_out), 1);
        check("gap_pend4", int'(pending), 2);
        drain("gap_drain");
        repeat (2) tick();

        // Edge mode: a held level is one event; a later edge is another.
        pulses  = 0;
        e_event = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) e_event = 1'b0;
            tick();
            if (e_pulse) pulses++;
        end
        check("edge_held", pulses, 1);
        e_event = 1'b1;
        tick();
        e_event = 1'b0;
        check("edge_second", int'(e_pulse), 1);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (e_pulse) pulses++;
        end
        check("edge_after", pulses, 0);

        // Asynchronous reset mid-cycle with seven events queued.
        event_in = 1'b1;
        repeat (10) tick();
        event_in = 1'b0;
        check("rst_pend7", int'(pending), 7);
        #3;
        rst_in_n = 1'b0;
        #1;
        check("arst_pulse", int'(pulse_out), 0);
        check("arst_pend", int'(pending), 0);
        check("arst_ovf", int'(overflow), 0);
        check("arst_busy", int'(busy), 0);
        @(negedge clk_in);
        rst_in_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (pulse_out) pulses++;
        end
        check("arst_no_pulses", pulses, 0);
        check("arst_pend_end", int'(pending), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
